// File: rtl/pc88_loader_sink.sv
// Loader byte sink: turns the LOADER_* level handshake into 16-bit SDRAM word
// writes with byte enables, and tracks download progress/completion/errors.
//
// state   | meaning
// IDLE    | waiting for LOADER_WR
// REQ     | mem_req held, waiting for mem_ack or timeout
// ACK     | LOADER_ACK pulse cycle
// WAITLOW | waiting for LOADER_WR to drop before accepting another byte
module pc88_loader_sink #(
  parameter logic [23:0] BASE_WADR = 24'h000000,
  parameter int          TMO       = 4095
) (
  input  logic        clk21m,
  input  logic        rstn,
  input  logic        LOADER_OE,
  input  logic        LOADER_WR,
  input  logic [18:0] LOADER_ADR,
  input  logic [7:0]  LOADER_WDAT,
  input  logic        LOADER_DONE,
  output logic        LOADER_ACK,
  output logic        mem_req,
  output logic [23:0] mem_wadr,
  output logic [15:0] mem_wdat,
  output logic [1:0]  mem_be,
  input  logic        mem_ack,
  output logic [19:0] ld_count,
  output logic        ld_complete,
  output logic        ld_err
);

  localparam int TW = (TMO < 1) ? 1 : $clog2(TMO + 1);
  localparam logic [TW-1:0] TMO_LD = TW'(TMO);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] ACK     = 2'd2;
  localparam logic [1:0] WAITLOW = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          ack_q, ack_d;
  logic          req_q, req_d;
  logic [23:0]   wadr_q, wadr_d;
  logic [15:0]   wdat_q, wdat_d;
  logic [1:0]    be_q, be_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [19:0]   cnt_q, cnt_d;
  logic          cmpl_q, cmpl_d;
  logic          err_q, err_d;
  logic          oe_q, oe_d;

  logic          oe_rise, oe_fall;
  logic          cnt_inc, err_set;
  logic [19:0]   cnt_base;

  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    req_d    = req_q;
    wadr_d   = wadr_q;
    wdat_d   = wdat_q;
    be_d     = be_q;
    tmr_d    = tmr_q;
    cnt_inc  = 1'b0;
    err_set  = 1'b0;
    oe_d     = LOADER_OE;
    oe_rise  = LOADER_OE & ~oe_q;
    oe_fall  = ~LOADER_OE & oe_q;

    case (state_q)
      IDLE: begin
        if (LOADER_WR) begin
          if (LOADER_OE) begin
            wadr_d  = BASE_WADR + {6'b0, LOADER_ADR[18:1]};
            wdat_d  = {LOADER_WDAT, LOADER_WDAT};
            be_d    = LOADER_ADR[0] ? 2'b10 : 2'b01;
            req_d   = 1'b1;
            tmr_d   = TMO_LD;
            state_d = REQ;
          end else begin
            // Outside the window: no write, but still ack so the initiator moves on.
            err_set = 1'b1;
            ack_d   = 1'b1;
            state_d = ACK;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          cnt_inc = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK;
        end else if (tmr_q == '0) begin
          req_d   = 1'b0;
          err_set = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ACK: begin
        state_d = WAITLOW;
      end
      default: begin
        if (!LOADER_WR) state_d = IDLE;
      end
    endcase

    // A window-open clear and an event in the same cycle: clear first, then apply.
    cnt_base = oe_rise ? 20'd0 : cnt_q;
    cnt_d    = (cnt_inc && (cnt_base != 20'hFFFFF)) ? cnt_base + 20'd1 : cnt_base;
    err_d    = (oe_rise ? 1'b0 : err_q) | err_set;

    if (oe_rise)                     cmpl_d = 1'b0;
    else if (oe_fall || LOADER_DONE) cmpl_d = 1'b1;
    else                             cmpl_d = cmpl_q;
  end

  always_ff @(posedge clk21m) begin
    if (!rstn) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      req_q   <= 1'b0;
      wadr_q  <= 24'd0;
      wdat_q  <= 16'd0;
      be_q    <= 2'b00;
      tmr_q   <= '0;
      cnt_q   <= 20'd0;
      cmpl_q  <= 1'b0;
      err_q   <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      req_q   <= req_d;
      wadr_q  <= wadr_d;
      wdat_q  <= wdat_d;
      be_q    <= be_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      cmpl_q  <= cmpl_d;
      err_q   <= err_d;
      oe_q    <= oe_d;
    end
  end

  assign LOADER_ACK  = ack_q;
  assign mem_req     = req_q;
  assign mem_wadr    = wadr_q;
  assign mem_wdat    = wdat_q;
  assign mem_be      = be_q;
  assign ld_count    = cnt_q;
  assign ld_complete = cmpl_q;
  assign ld_err      = err_q;

endmodule

// File: tb/tb_pc88_loader_sink.sv
// Bench for pc88_loader_sink: two instances (zero and wrapping base address)
// driven in lockstep, write contents checked through an expected-value queue.
module tb_pc88_loader_sink;

  localparam logic [23:0] BASE_A = 24'h000000;
  localparam logic [23:0] BASE_B = 24'hFFFFF0;
  localparam int          TMO_T  = 15;

  logic        clk21m = 1'b0;
  logic        rstn;
  logic        LOADER_OE, LOADER_WR, LOADER_DONE, mem_ack;
  logic [18:0] LOADER_ADR;
  logic [7:0]  LOADER_WDAT;

  logic        LOADER_ACK, mem_req, ld_complete, ld_err;
  logic [23:0] mem_wadr;
  logic [15:0] mem_wdat;
  logic [1:0]  mem_be;
  logic [19:0] ld_count;

  logic        b_ack, b_req, b_cmpl, b_err;
  logic [23:0] b_wadr;
  logic [15:0] b_wdat;
  logic [1:0]  b_be;
  logic [19:0] b_count;

  pc88_loader_sink #(.BASE_WADR(BASE_A), .TMO(TMO_T)) u_dut (
    .clk21m(clk21m), .rstn(rstn), .LOADER_OE(LOADER_OE), .LOADER_WR(LOADER_WR),
    .LOADER_ADR(LOADER_ADR), .LOADER_WDAT(LOADER_WDAT), .LOADER_DONE(LOADER_DONE),
    .LOADER_ACK(LOADER_ACK), .mem_req(mem_req), .mem_wadr(mem_wadr),
    .mem_wdat(mem_wdat), .mem_be(mem_be), .mem_ack(mem_ack),
    .ld_count(ld_count), .ld_complete(ld_complete), .ld_err(ld_err)
  );

  pc88_loader_sink #(.BASE_WADR(BASE_B), .TMO(TMO_T)) u_dut_b (
    .clk21m(clk21m), .rstn(rstn), .LOADER_OE(LOADER_OE), .LOADER_WR(LOADER_WR),
    .LOADER_ADR(LOADER_ADR), .LOADER_WDAT(LOADER_WDAT), .LOADER_DONE(LOADER_DONE),
    .LOADER_ACK(b_ack), .mem_req(b_req), .mem_wadr(b_wadr),
    .mem_wdat(b_wdat), .mem_be(b_be), .mem_ack(mem_ack),
    .ld_count(b_count), .ld_complete(b_cmpl), .ld_err(b_err)
  );

  always #5 clk21m = ~clk21m;

  typedef struct packed {
    logic [23:0] wadr_a;
    logic [23:0] wadr_b;
    logic [15:0] wdat;
    logic [1:0]  be;
  } sb_t;

  sb_t         sb_q[$];
  sb_t         sb_e;
  int          n_chk = 0;
  int          n_err = 0;
  int          req_rises = 0;
  int          ack_highs = 0;
  logic        req_prev = 1'b0;
  logic [23:0] hold_wadr = '0;
  logic [15:0] hold_wdat = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: each new mem_req must carry the next expected write.
  always @(negedge clk21m) begin
    if (LOADER_ACK) ack_highs++;
    if (mem_req && !req_prev) begin
      req_rises++;
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        sb_e = sb_q.pop_front();
        chk("wadr",   32'(mem_wadr), 32'(sb_e.wadr_a));
        chk("wadr_b", 32'(b_wadr),   32'(sb_e.wadr_b));
        chk("wdat",   32'(mem_wdat), 32'(sb_e.wdat));
        chk("be",     32'(mem_be),   32'(sb_e.be));
        hold_wadr = mem_wadr;
        hold_wdat = mem_wdat;
      end
    end else if (mem_req && req_prev) begin
      chk("wadr_stable", 32'(mem_wadr), 32'(hold_wadr));
      chk("wdat_stable", 32'(mem_wdat), 32'(hold_wdat));
    end
    req_prev = mem_req;
  end

  task automatic push_exp(input logic [18:0] adr, input logic [7:0] dat);
    sb_t e;
    e.wadr_a = BASE_A + {6'b0, adr[18:1]};
    e.wadr_b = BASE_B + {6'b0, adr[18:1]};
    e.wdat   = {dat, dat};
    e.be     = adr[0] ? 2'b10 : 2'b01;
    sb_q.push_back(e);
  endtask

  // ack_dly < 0: arbiter never acks. hold: extra cycles WR stays high after the ACK.
  task automatic do_write(input logic [18:0] adr, input logic [7:0] dat,
                          input int ack_dly, input int hold);
    int n, rc, exp_lat, exp_rc;
    logic got;
    logic oe;
    @(posedge clk21m); #1;
    oe = LOADER_OE;
    if (oe) push_exp(adr, dat);
    LOADER_WR = 1'b1; LOADER_ADR = adr; LOADER_WDAT = dat;
    n = 0; rc = 0; got = 1'b0;
    while (n < 200) begin
      @(negedge clk21m);
      n++;
      mem_ack = 1'b0;
      if (LOADER_ACK) begin
        got = 1'b1;
        break;
      end
      if (mem_req) begin
        rc++;
        if (ack_dly >= 0 && rc == ack_dly + 1) mem_ack = 1'b1;
      end
    end
    if (!got) chk("ack_timeout", 32'(got), 32'd1);
    exp_rc  = !oe ? 0 : (ack_dly >= 0 ? ack_dly + 1 : TMO_T + 1);
    exp_lat = !oe ? 2 : (ack_dly >= 0 ? ack_dly + 3 : TMO_T + 3);
    chk("req_cycles", 32'(rc), 32'(exp_rc));
    chk("ack_latency", 32'(n), 32'(exp_lat));
    @(negedge clk21m);
    chk("ack_one_cycle", 32'(LOADER_ACK), 32'd0);
    repeat (hold) @(posedge clk21m);
    @(posedge clk21m); #1;
    LOADER_WR = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, a0, n;
    rstn = 1'b0; LOADER_OE = 1'b0; LOADER_WR = 1'b0; LOADER_DONE = 1'b0;
    LOADER_ADR = '0; LOADER_WDAT = '0; mem_ack = 1'b0;
    repeat (3) @(posedge clk21m);
    @(negedge clk21m);
    chk("rst_ack",  32'(LOADER_ACK),  32'd0);
    chk("rst_req",  32'(mem_req),     32'd0);
    chk("rst_wadr", 32'(mem_wadr),    32'd0);
    chk("rst_wdat", 32'(mem_wdat),    32'd0);
    chk("rst_be",   32'(mem_be),      32'd0);
    chk("rst_cnt",  32'(ld_count),    32'd0);
    chk("rst_cmpl", 32'(ld_complete), 32'd0);
    chk("rst_err",  32'(ld_err),      32'd0);
    @(posedge clk21m); #1;
    rstn = 1'b1; LOADER_OE = 1'b1;
    repeat (2) @(posedge clk21m);

    // Basic write, ack one cycle after req.
    do_write(19'h00004, 8'hA5, 1, 0);
    chk("t1_cnt", 32'(ld_count), 32'd1);
    chk("t1_err", 32'(ld_err), 32'd0);

    // Top byte address, high byte lane, wrapping base on instance b.
    do_write(19'h7FFFF, 8'h3C, 0, 0);
    chk("t2_cnt", 32'(ld_count), 32'd2);

    // WR held high long after the ACK: only one memory write.
    r0 = req_rises;
    do_write(19'h00010, 8'h11, 0, 10);
    chk("t3_one_req", 32'(req_rises - r0), 32'd1);
    chk("t3_cnt", 32'(ld_count), 32'd3);
    do_write(19'h00011, 8'h22, 2, 0);
    chk("t3_second_req", 32'(req_rises - r0), 32'd2);
    chk("t3_cnt2", 32'(ld_count), 32'd4);

    // Arbiter never acks: timeout path.
    do_write(19'h00020, 8'h55, -1, 0);
    chk("t4_err", 32'(ld_err), 32'd1);
    chk("t4_cnt", 32'(ld_count), 32'd4);

    // Close and reopen the window: everything clears.
    @(posedge clk21m); #1; LOADER_OE = 1'b0;
    @(posedge clk21m); #1; LOADER_OE = 1'b1;
    @(negedge clk21m); @(negedge clk21m);
    chk("reopen_cnt",  32'(ld_count),    32'd0);
    chk("reopen_err",  32'(ld_err),      32'd0);
    chk("reopen_cmpl", 32'(ld_complete), 32'd0);

    // Three writes then window closes.
    do_write(19'h00100, 8'h01, 0, 0);
    do_write(19'h00101, 8'h02, 1, 0);
    do_write(19'h00102, 8'h03, 3, 0);
    @(posedge clk21m); #1; LOADER_OE = 1'b0;
    @(negedge clk21m); @(negedge clk21m);
    chk("close_cmpl", 32'(ld_complete), 32'd1);
    chk("close_cnt",  32'(ld_count),    32'd3);
    chk("close_err",  32'(ld_err),      32'd0);

    // Write with the window closed: no memory request, quick ACK, error flag.
    r0 = req_rises;
    do_write(19'h00200, 8'h66, -1, 0);
    chk("t5_no_req", 32'(req_rises - r0), 32'd0);
    chk("t5_err", 32'(ld_err), 32'd1);
    chk("t5_cnt", 32'(ld_count), 32'd3);

    // Reopen clears; DONE sets complete.
    @(posedge clk21m); #1; LOADER_OE = 1'b1;
    @(negedge clk21m); @(negedge clk21m);
    chk("reopen2_cnt",  32'(ld_count),    32'd0);
    chk("reopen2_err",  32'(ld_err),      32'd0);
    chk("reopen2_cmpl", 32'(ld_complete), 32'd0);
    @(posedge clk21m); #1; LOADER_DONE = 1'b1;
    @(posedge clk21m); #1; LOADER_DONE = 1'b0;
    @(negedge clk21m);
    chk("done_cmpl", 32'(ld_complete), 32'd1);
    @(negedge clk21m);
    chk("done_sticky", 32'(ld_complete), 32'd1);

    // Reset while a write is pending.
    @(posedge clk21m); #1;
    push_exp(19'h00300, 8'h77);
    LOADER_WR = 1'b1; LOADER_ADR = 19'h00300; LOADER_WDAT = 8'h77;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk21m);
      n++;
    end
    chk("rst_req_seen", 32'(mem_req), 32'd1);
    a0 = ack_highs;
    @(posedge clk21m); #1;
    rstn = 1'b0; LOADER_WR = 1'b0;
    @(negedge clk21m);
    chk("midrst_req_still", 32'(mem_req), 32'd1);
    @(negedge clk21m);
    chk("midrst_req",  32'(mem_req),     32'd0);
    chk("midrst_ack",  32'(LOADER_ACK),  32'd0);
    chk("midrst_wadr", 32'(mem_wadr),    32'd0);
    chk("midrst_cmpl", 32'(ld_complete), 32'd0);
    @(posedge clk21m); #1; rstn = 1'b1;
    repeat (6) @(negedge clk21m);
    chk("midrst_no_ack", 32'(ack_highs - a0), 32'd0);
    chk("midrst_no_req", 32'(mem_req), 32'd0);

    chk("sb_left", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
